// File: rtl/mult_arbiter_if.sv
// Handshake and multiplier-bus bundle for mult_arbiter.
// The slave modport is the arbiter; master is the requester/multiplier side.
interface mult_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                      enable;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*DATA_W-1:0]   req_a;
    logic [N_REQ*DATA_W-1:0]   req_b;
    logic [N_REQ-1:0]          req_ready;
    logic                      mult_enable;
    logic [DATA_W-1:0]         mult_a;
    logic [DATA_W-1:0]         mult_b;
    logic [DATA_W-1:0]         mult_result;
    logic                      resp_valid;
    logic [IdW-1:0]            resp_id;
    logic [DATA_W-1:0]         resp_data;
    logic [1:0]                inflight;

    modport master (
        output enable, req_valid, req_a, req_b, mult_result,
        input  req_ready, mult_enable, mult_a, mult_b, resp_valid, resp_id, resp_data, inflight
    );

    modport slave (
        input  enable, req_valid, req_a, req_b, mult_result,
        output req_ready, mult_enable, mult_a, mult_b, resp_valid, resp_id, resp_data, inflight
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding a shared 2-cycle multiplier, with a 2-stage
// {valid, id} tag pipeline that routes each product back to its requester.
module mult_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    mult_arbiter_if.slave bus
);
    localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IdW-1:0]   last_grant_q, last_grant_d;
    logic             s1_valid_q, s2_valid_q;
    logic [IdW-1:0]   s1_id_q, s2_id_q;

    logic             active;
    logic             transfer;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic [IdW-1:0]   grant_id;
    int unsigned      idx;

    assign active = bus.enable & ~reset;

    // Search begins one past the last winner so every requester rotates to top priority.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IdW'(idx);
            end
        end
    end

    assign transfer        = active & found;
    assign bus.req_ready   = active ? grant : '0;
    assign bus.mult_enable = active;
    assign bus.mult_a      = transfer ? bus.req_a[32'(grant_id)*DATA_W +: DATA_W] : '0;
    assign bus.mult_b      = transfer ? bus.req_b[32'(grant_id)*DATA_W +: DATA_W] : '0;

    always_comb begin
        last_grant_d = last_grant_q;
        if (transfer) begin
            last_grant_d = grant_id;
        end
    end

    // Tag stages advance in lock-step with the multiplier pipeline, frozen by enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= IdW'(N_REQ - 1);
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= '0;
        end else if (bus.enable) begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= transfer;
            s1_id_q      <= transfer ? grant_id : '0;
            s2_valid_q   <= s1_valid_q;
            s2_id_q      <= s1_id_q;
        end
    end

    assign bus.resp_valid = s2_valid_q & active;
    assign bus.resp_id    = bus.resp_valid ? s2_id_q : '0;
    assign bus.resp_data  = bus.resp_valid ? bus.mult_result : '0;
    assign bus.inflight   = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus held-operand random traffic,
// checked against a queue-of-pending-operations reference model.
module tb_mult_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned PW  = N * W;
    localparam int unsigned IdW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    mult_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared multiplier: product appears two enabled edges after the operands.
    logic [W-1:0]   p1, p2;
    logic [2*W-1:0] full;
    assign full = bus.mult_a * bus.mult_b;
    always @(posedge clk) begin
        if (bus.mult_enable) begin
            p1 <= full[W-1:0];
            p2 <= p1;
        end
    end
    assign bus.mult_result = p2;

    typedef struct {
        int id;
        int prod;
        int age;
    } op_t;

    op_t  q[$];
    int   last_grant;
    int   vectors;
    int   miscompares;

    logic [N-1:0]   exp_ready;
    logic [N-1:0]   obs_ready;
    logic           obs_rv;
    logic [IdW-1:0] obs_id;
    logic [W-1:0]   obs_data;
    logic [1:0]     obs_inflight;

    logic [N-1:0]   cur_v;
    logic [PW-1:0]  cur_a, cur_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] put(input int slot, input int val);
        logic [PW-1:0] r;
        r = '0;
        r[slot*W +: W] = W'(val);
        return r;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [PW-1:0] a, input logic [PW-1:0] b,
                        input logic en, input logic rst);
        int       gidx;
        logic     act;
        logic     exp_rv;
        int       exp_id, exp_data, exp_ma, exp_mb;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.enable    = en;
        reset         = rst;
        #1;
        act  = en && !rst;
        gidx = -1;
        if (act) begin
            for (int k = 1; k <= int'(N); k++) begin
                int i;
                i = (last_grant + k) % N;
                if (gidx < 0 && v[i]) gidx = i;
            end
        end
        exp_ready = '0;
        exp_ma    = 0;
        exp_mb    = 0;
        if (gidx >= 0) begin
            exp_ready[gidx] = 1'b1;
            exp_ma = int'(a[gidx*W +: W]);
            exp_mb = int'(b[gidx*W +: W]);
        end
        exp_rv   = act && q.size() > 0 && q[0].age == 2;
        exp_id   = exp_rv ? q[0].id : 0;
        exp_data = exp_rv ? q[0].prod : 0;

        obs_ready    = bus.req_ready;
        obs_rv       = bus.resp_valid;
        obs_id       = bus.resp_id;
        obs_data     = bus.resp_data;
        obs_inflight = bus.inflight;

        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("mult_enable", 32'(bus.mult_enable), 32'(act));
        check("mult_a", 32'(bus.mult_a), 32'(exp_ma));
        check("mult_b", 32'(bus.mult_b), 32'(exp_mb));
        check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        check("resp_id", 32'(bus.resp_id), 32'(exp_id));
        check("resp_data", 32'(bus.resp_data), 32'(exp_data));
        check("inflight", 32'(bus.inflight), 32'(q.size()));

        @(posedge clk);
        if (rst) begin
            q.delete();
            last_grant = N - 1;
        end else if (en) begin
            if (exp_rv) void'(q.pop_front());
            foreach (q[j]) q[j].age++;
            if (gidx >= 0) begin
                q.push_back('{id: gidx, prod: (exp_ma * exp_mb) % (1 << W), age: 1});
                last_grant = gidx;
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        last_grant    = N - 1;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset state
        step('0, '0, '0, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b1);
        check("rst_ready", 32'(obs_ready), 32'(0));
        step('0, '0, '0, 1'b1, 1'b0);
        check("idle_inflight", 32'(obs_inflight), 32'(0));

        // Single op on requester 2
        step(4'b0100, put(2, 3), put(2, 5), 1'b1, 1'b0);
        check("single_ready", 32'(obs_ready), 32'(4'b0100));
        step('0, '0, '0, 1'b1, 1'b0);
        check("single_infl1", 32'(obs_inflight), 32'(1));
        step('0, '0, '0, 1'b1, 1'b0);
        check("single_rv", 32'(obs_rv), 32'(1));
        check("single_id", 32'(obs_id), 32'(2));
        check("single_data", 32'(obs_data), 32'(15));
        check("single_infl2", 32'(obs_inflight), 32'(1));
        step('0, '0, '0, 1'b1, 1'b0);
        check("single_infl3", 32'(obs_inflight), 32'(0));

        // All requesters valid continuously from reset
        step('0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'b1111, PW'($urandom), PW'($urandom), 1'b1, 1'b0);
            check("rr_grant", 32'(obs_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check("rr_id", 32'(obs_id), 32'((k - 2) % 4));
                check("rr_infl", 32'(obs_inflight), 32'(2));
            end
        end
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);

        // Truncation
        step(4'b0001, put(0, 20), put(0, 20), 1'b1, 1'b0);
        step(4'b0001, put(0, 255), put(0, 255), 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        check("trunc_400", 32'(obs_data), 32'(144));
        step('0, '0, '0, 1'b1, 1'b0);
        check("trunc_ff", 32'(obs_data), 32'(1));
        step('0, '0, '0, 1'b1, 1'b0);

        // Enable low with two in flight
        step(4'b0001, put(0, 2), put(0, 3), 1'b1, 1'b0);
        step(4'b0010, put(1, 4), put(1, 5), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, '1, '1, 1'b0, 1'b0);
            check("frz_ready", 32'(obs_ready), 32'(0));
            check("frz_rv", 32'(obs_rv), 32'(0));
            check("frz_infl", 32'(obs_inflight), 32'(2));
        end
        step('0, '0, '0, 1'b1, 1'b0);
        check("thaw_id0", 32'(obs_id), 32'(0));
        check("thaw_d0", 32'(obs_data), 32'(6));
        step('0, '0, '0, 1'b1, 1'b0);
        check("thaw_id1", 32'(obs_id), 32'(1));
        check("thaw_d1", 32'(obs_data), 32'(20));
        step('0, '0, '0, 1'b1, 1'b0);

        // Reset mid-flight, then requesters 0 and 3
        step(4'b0100, put(2, 7), put(2, 7), 1'b1, 1'b0);
        step(4'b1000, put(3, 9), put(3, 9), 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b1);
        step(4'b1001, put(0, 1) | put(3, 2), put(0, 1) | put(3, 2), 1'b1, 1'b0);
        check("rst_first", 32'(obs_ready), 32'(4'b0001));
        check("rst_norv", 32'(obs_rv), 32'(0));
        step('0, '0, '0, 1'b1, 1'b0);
        check("rst_norv2", 32'(obs_rv), 32'(0));
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);

        // Fairness: after 1 wins, 3 beats 0
        step(4'b0010, put(1, 1), put(1, 1), 1'b1, 1'b0);
        step(4'b1001, put(0, 1) | put(3, 2), put(0, 1) | put(3, 2), 1'b1, 1'b0);
        check("fair_3", 32'(obs_ready), 32'(4'b1000));
        step(4'b0001, put(0, 1), put(0, 1), 1'b1, 1'b0);
        check("fair_0", 32'(obs_ready), 32'(4'b0001));

        // Random traffic; operands held while valid and not granted
        cur_v = '0;
        cur_a = '0;
        cur_b = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!(cur_v[i] && !exp_ready[i])) begin
                    cur_v[i]         = 1'($urandom_range(0, 1));
                    cur_a[i*W +: W]  = W'($urandom);
                    cur_b[i*W +: W]  = W'($urandom);
                end
            end
            step(cur_v, cur_a, cur_b, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
